// File: rtl/token_rate_divider_if.sv
// Token lanes, ratio/mode programming strobe and status readback for token_rate_divider.
interface token_rate_divider_if #(
  parameter int CHANNELS = 4,
  parameter int CNT_W    = 4
);
  logic [CHANNELS-1:0]       a;
  logic [CHANNELS-1:0]       b;
  logic                      load;
  logic [CNT_W-1:0]          ratio;
  logic                      keep_first;
  logic [CNT_W-1:0]          cur_ratio;
  logic [CHANNELS*CNT_W-1:0] group_pos;

  modport master (
    output a, load, ratio, keep_first,
    input  b, cur_ratio, group_pos
  );

  modport slave (
    input  a, load, ratio, keep_first,
    output b, cur_ratio, group_pos
  );
endinterface

// File: rtl/token_rate_divider.sv
// Per-lane token thinner: passes one token out of every R on each lane,
// keeping either the first or the last token of each group.
module token_rate_divider #(
  parameter int CHANNELS           = 4,
  parameter int CNT_W              = 4,
  parameter int DEFAULT_RATIO      = 2,
  parameter int DEFAULT_KEEP_FIRST = 0
) (
  input logic               clk,
  input logic               rst,
  token_rate_divider_if.slave bus
);

  localparam logic [CNT_W-1:0] LP_ONE       = CNT_W'(1);
  localparam logic [CNT_W-1:0] LP_DEF_RATIO = (DEFAULT_RATIO == 0) ? LP_ONE : CNT_W'(DEFAULT_RATIO);
  localparam logic             LP_DEF_KF    = (DEFAULT_KEEP_FIRST != 0);

  // r_ratio always holds the effective ratio (never 0), so no max() is needed downstream.
  logic [CNT_W-1:0]          r_ratio;
  logic                      r_keep_first;
  logic [CNT_W-1:0]          w_last;
  logic                      w_block;
  logic [CHANNELS-1:0]       w_b;
  logic [CHANNELS*CNT_W-1:0] w_group_pos;

  assign w_last  = r_ratio - LP_ONE;
  assign w_block = rst | bus.load;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ratio      <= LP_DEF_RATIO;
      r_keep_first <= LP_DEF_KF;
    end else if (bus.load) begin
      r_ratio      <= (bus.ratio == '0) ? LP_ONE : bus.ratio;
      r_keep_first <= bus.keep_first;
    end
  end

  generate
    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_lane
      logic [CNT_W-1:0] r_cnt;
      logic             w_at_last;
      logic             w_hit;

      assign w_at_last = (r_cnt == w_last);
      assign w_hit     = r_keep_first ? (r_cnt == '0) : w_at_last;
      assign w_b[gi]   = bus.a[gi] & w_hit & ~w_block;
      assign w_group_pos[gi*CNT_W +: CNT_W] = r_cnt;

      // Tokens seen during reset or a load cycle are discarded, not counted.
      always_ff @(posedge clk) begin
        if (rst || bus.load) begin
          r_cnt <= '0;
        end else if (bus.a[gi]) begin
          r_cnt <= w_at_last ? '0 : r_cnt + LP_ONE;
        end
      end
    end
  endgenerate

  assign bus.b         = w_b;
  assign bus.cur_ratio = r_ratio;
  assign bus.group_pos = w_group_pos;

endmodule

// File: tb/tb_token_rate_divider.sv
// Scoreboarded bench for token_rate_divider: directed scenarios plus random traffic
// against a token-count reference model.
module tb_token_rate_divider;
  localparam int CH    = 4;
  localparam int CW    = 4;
  localparam int DEF_R = 2;
  localparam int DEF_K = 0;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  token_rate_divider_if #(.CHANNELS(CH), .CNT_W(CW)) bus ();

  token_rate_divider #(
    .CHANNELS(CH), .CNT_W(CW),
    .DEFAULT_RATIO(DEF_R), .DEFAULT_KEEP_FIRST(DEF_K)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct packed {
    logic [CH-1:0]    a;
    logic [CH-1:0]    b;
    logic [CW-1:0]    cur;
    logic [CH*CW-1:0] gp;
    logic             chk;
  } exp_t;

  exp_t          sb[$];
  logic [CH-1:0] cap[$];
  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  // Model: tokens counted since the current group sequence began, plus ratio/mode.
  int m_reff = DEF_R;
  int m_seen[CH];
  bit m_kf = (DEF_K != 0);
  bit m_known = 1'b0;

  task automatic step(input logic [CH-1:0] a_in, input logic ld,
                      input logic [CW-1:0] rat, input logic kf, input logic rs);
    exp_t e;
    rst            = rs;
    bus.a          = a_in;
    bus.load       = ld;
    bus.ratio      = rat;
    bus.keep_first = kf;
    e.a   = a_in;
    e.chk = m_known;
    e.cur = CW'(m_reff);
    e.b   = '0;
    e.gp  = '0;
    for (int i = 0; i < CH; i++) begin
      int pos;
      pos = m_seen[i] % m_reff;
      e.gp[i*CW +: CW] = CW'(pos);
      if (a_in[i] && !ld && !rs)
        e.b[i] = m_kf ? (pos == 0) : (pos == m_reff - 1);
    end
    sb.push_back(e);
    if (rs) begin
      m_reff  = DEF_R;
      m_kf    = (DEF_K != 0);
      m_known = 1'b1;
      for (int i = 0; i < CH; i++) m_seen[i] = 0;
    end else if (ld) begin
      m_reff = (rat == 0) ? 1 : int'(rat);
      m_kf   = kf;
      for (int i = 0; i < CH; i++) m_seen[i] = 0;
    end else begin
      for (int i = 0; i < CH; i++) if (a_in[i]) m_seen[i]++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic lane_seq(input string name, input int lane, input int n, input logic [63:0] exp);
    logic [63:0] got;
    got = '0;
    for (int k = 0; k < cap.size() && k < 64; k++) got[n-1-k] = cap[k][lane];
    tests++;
    if (cap.size() != n || got != exp) begin
      fails++;
      $display("FAIL %s lane%0d: got=%b (len %0d) exp=%b (len %0d)", name, lane,
               got[31:0], cap.size(), exp[31:0], n);
    end
  endtask

  task automatic chk_val(input string name, input int got, input int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got=%0d exp=%0d", name, got, exp);
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      cap.push_back(bus.b);
      $display("[TB] cyc=%0d a=%h b=%h cur=%0d gp=%h", cyc, e.a, bus.b, bus.cur_ratio, bus.group_pos);
      tests++;
      if (bus.b !== e.b) begin
        fails++;
        $display("FAIL b cyc=%0d got=%h exp=%h", cyc, bus.b, e.b);
      end
      if (e.chk) begin
        tests++;
        if (bus.cur_ratio !== e.cur) begin
          fails++;
          $display("FAIL cur_ratio cyc=%0d got=%0d exp=%0d", cyc, bus.cur_ratio, e.cur);
        end
        tests++;
        if (bus.group_pos !== e.gp) begin
          fails++;
          $display("FAIL group_pos cyc=%0d got=%h exp=%h", cyc, bus.group_pos, e.gp);
        end
      end
      cyc++;
    end
  end

  initial begin
    int outs;
    rst = 1'b1;
    bus.a = '0; bus.load = 1'b0; bus.ratio = '0; bus.keep_first = 1'b0;
    for (int i = 0; i < CH; i++) m_seen[i] = 0;
    @(posedge clk);
    #1;
    step('0, 0, 0, 0, 1);
    step('0, 0, 0, 0, 0);
    chk_val("reset cur_ratio", int'(bus.cur_ratio), DEF_R);
    chk_val("reset group_pos", int'(bus.group_pos), 0);

    // Default R=2 keep-last on lane 0.
    begin
      logic [15:0] pat;
      pat = 16'b1100111010001111;
      cap.delete();
      for (int k = 15; k >= 0; k--) step({3'b000, pat[k]}, 0, 0, 0, 0);
      lane_seq("default_r2", 0, 16, 64'b0100010010000101);
    end

    // R=3 keep-first, 7 tokens.
    step('0, 1, 3, 1, 0);
    cap.delete();
    repeat (7) step(4'b0001, 0, 0, 0, 0);
    lane_seq("r3_keep_first", 0, 7, 64'b1001001);
    chk_val("r3 cur_ratio", int'(bus.cur_ratio), 3);

    // Ratio 0 becomes pass-through.
    step('0, 1, 0, 0, 0);
    chk_val("r0 cur_ratio", int'(bus.cur_ratio), 1);
    cap.delete();
    step(4'b0001, 0, 0, 0, 0);
    step(4'b0000, 0, 0, 0, 0);
    step(4'b0001, 0, 0, 0, 0);
    step(4'b0001, 0, 0, 0, 0);
    lane_seq("passthru", 0, 4, 64'b1011);

    // Lane independence, R=2 keep-last.
    step('0, 1, 2, 0, 0);
    cap.delete();
    for (int c = 0; c < 8; c++) step({2'b00, (c % 2 == 0), 1'b1}, 0, 0, 0, 0);
    lane_seq("lanes_l0", 0, 8, 64'b01010101);
    lane_seq("lanes_l1", 1, 8, 64'b00100010);
    lane_seq("lanes_l2", 2, 8, 64'b0);
    lane_seq("lanes_l3", 3, 8, 64'b0);

    // Mid-group reset, R=4.
    step('0, 1, 4, 0, 0);
    cap.delete();
    repeat (3) step(4'b0001, 0, 0, 0, 0);
    chk_val("mid gp before rst", int'(bus.group_pos[CW-1:0]), 3);
    step(4'b0001, 0, 0, 0, 1);
    step(4'b0000, 1, 4, 0, 0);
    repeat (4) step(4'b0001, 0, 0, 0, 0);
    lane_seq("mid_rst", 0, 9, 64'b000000001);

    // Mid-group load, R=4.
    step('0, 1, 4, 0, 0);
    cap.delete();
    repeat (3) step(4'b0001, 0, 0, 0, 0);
    step(4'b0001, 1, 4, 0, 0);
    repeat (4) step(4'b0001, 0, 0, 0, 0);
    lane_seq("mid_load", 0, 8, 64'b00000001);

    // Reset beats load; then R=15 sweep.
    step('0, 1, 5, 1, 1);
    chk_val("rst_over_load cur", int'(bus.cur_ratio), DEF_R);
    step('0, 1, 15, 0, 0);
    cap.delete();
    repeat (30) step(4'b0001, 0, 0, 0, 0);
    lane_seq("r15_sweep", 0, 30, 64'h8001);
    outs = 0;
    foreach (cap[k]) outs += int'(cap[k][0]);
    chk_val("r15 out count", outs, 2);

    // Random traffic with occasional loads and resets.
    for (int n = 0; n < 400; n++) begin
      step(CH'($urandom), ($urandom_range(0, 19) == 0), CW'($urandom),
           1'($urandom), ($urandom_range(0, 49) == 0));
    end

    @(negedge clk);
    #1;
    chk_val("scoreboard drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/token_rate_divider.md
# token_rate_divider

Multi-channel serial token thinner: on each channel, exactly one of every R incoming `1` tokens passes to the output and the rest are dropped. The divide ratio R and the keep position (first or last token of each group) are runtime-programmable. Halving is the case R=2, keep-last. The block sits in the sequential-basics serial-stream path, between token sources and downstream counters or consumers.

## Interface
Parameters:
- `CHANNELS`, default 4: number of independent token lanes (≥1).
- `CNT_W`, default 4: width of the ratio and of each per-channel group counter. Maximum R = 2^CNT_W−1.
- `DEFAULT_RATIO`, default 2: ratio register reset value (1..2^CNT_W−1).
- `DEFAULT_KEEP_FIRST`, default 0: mode register reset value.

Ports:
- `clk` input 1: single clock, all state updates on posedge.
- `rst` input 1: synchronous, active-high reset.
- `a` input CHANNELS: per-channel token input; bit i = 1 means one token this cycle.
- `b` output CHANNELS: per-channel thinned token output; same-cycle (combinational from `a` and registered state).
- `load` input 1: one-cycle strobe; captures `ratio` and `keep_first` and restarts all groups.
- `ratio` input CNT_W: new divide ratio, sampled only when `load`=1.
- `keep_first` input 1: new mode, sampled only when `load`=1. 1 = pass the first token of each group; 0 = pass the last.
- `cur_ratio` output CNT_W: effective ratio currently in force.
- `group_pos` output CHANNELS*CNT_W: per-channel counter value; channel i occupies bits [i*CNT_W +: CNT_W].

## Operation
- State: ratio register `R`, mode register `K`, one counter `cnt[i]` per channel, each in range 0..Reff−1.
- Effective ratio: Reff = max(R, 1). A loaded `ratio`=0 is stored as 1, and `cur_ratio` shows 1. When Reff=1, `b`=`a` (pass-through) and counters stay 0.
- Channels are fully independent. A token on one lane never affects another lane.
- For channel i with `a[i]`=1 and `load`=0:
  - Hit condition: `cnt[i]` == Reff−1 when K=0, or `cnt[i]` == 0 when K=1.
  - `b[i]` = hit.
  - Next `cnt[i]` = (`cnt[i]` == Reff−1) ? 0 : `cnt[i]`+1. The counter wraps; it never saturates.
- For channel i with `a[i]`=0: `b[i]`=0 and `cnt[i]` holds.
- `b` is never 1 unless the matching bit of `a` is 1.
- Over any window that starts at a group boundary, the number of output tokens = floor(input tokens / Reff) for K=0, and ceil(input tokens / Reff) for K=1.
- Load cycle (`load`=1):
  - `b` is forced to all zeros, and tokens arriving in that cycle are discarded (not counted).
  - Next cycle: R ← (`ratio`==0 ? 1 : `ratio`), K ← `keep_first`, all `cnt` ← 0.
- Reset, effective the cycle after `rst` is sampled high:
  - R = DEFAULT_RATIO, K = DEFAULT_KEEP_FIRST, all `cnt` = 0.
  - While `rst`=1, `b` is forced to all zeros.
  - `rst` has priority over `load`.
- Reset mid-group: any partial count is discarded. The next token starts a new group.

## Timing
- `b` latency: 0 cycles, combinational from `a`, `cnt`, R, K, `load`, `rst`. No registered output stage.
- Counter, R and K updates: visible 1 cycle after the causing edge.
- `cur_ratio` and `group_pos` are registered. After a `load` in cycle t, they reflect the new values from cycle t+1.
- Outputs under reset: `b`=0, `cur_ratio`=DEFAULT_RATIO, `group_pos`=0 from the cycle after `rst` is sampled.
- Throughput: one token per channel per cycle, no stalls, no back-pressure.
- Back-to-back `load` strobes are legal. Each one clears the counters, and the last one wins.

## Test plan
- Default config (R=2, K=0), one lane, `a`=110_011_101_000_1111 → `b`=010_001_001_000_0101; `group_pos` alternates 0/1 on token cycles only.
- `load` with `ratio`=3, `keep_first`=1, then 7 consecutive tokens → `b`=1001001; `cur_ratio`=3.
- `load` with `ratio`=0, then `a`=1011 → `b`=1011 (pass-through); `cur_ratio`=1.
- CHANNELS=4, R=2, K=0: lane0 gets continuous tokens, lane1 gets tokens on alternate cycles, lanes 2–3 idle. Required: lane0 passes tokens 2, 4, …; lane1 passes its 2nd, 4th, …; lanes 2–3 stay 0; no cross-lane interference.
- Mid-group disruption, R=4 K=0:
  - Give 3 tokens (`group_pos`=3), assert `rst` for 1 cycle with `a`=1 → `b`=0.
  - Then 4 tokens → only the 4th passes.
  - Repeat with `load` in place of `rst` → same result.
- Simultaneous `rst` and `load` with `ratio`=5 → `cur_ratio` = DEFAULT_RATIO afterwards. Then sweep R=15 (CNT_W=4) with 30 tokens → exactly 2 outputs, at tokens 15 and 30.
